tohost_monitor: RTL and testbench
=================================

# tohost_monitor

Pass/fail detector inside the test harness whose registered `io_success` output drives the top-level driver's success input. It snoops the target's memory write channel for stores to the `tohost` address and decodes exit commands into sticky success/failure. It buffers non-exit host commands in a small FIFO for the host-side proxy. A no-progress watchdog converts a hung target into a failure.

## Interface
- `ADDR_W`, 32, write address width
- `DATA_W`, 64, write data width (≥ 33)
- `TOHOST_ADDR`, 32'h8000_1000, byte address of `tohost`
- `FIFO_DEPTH`, 4, command FIFO entries (power of 2, ≥ 2)
- `TIMEOUT_CYCLES`, 0, watchdog limit in cycles; 0 disables

Ports:
- `clock`  in  1  sole clock; all state updates on rising edge
- `reset`  in  1  synchronous, active-high
- `wr_valid`  in  1  write request valid
- `wr_ready`  out  1  write request accepted when `wr_valid && wr_ready`
- `wr_addr`  in  ADDR_W  write byte address
- `wr_data`  in  DATA_W  write data
- `wr_strb`  in  DATA_W/8  byte strobes
- `retire`  in  1  instruction-retired pulse (progress indication)
- `cmd_valid`  out  1  FIFO head valid
- `cmd_ready`  in  1  host proxy consumes head
- `cmd_data`  out  DATA_W  FIFO head data
- `io_success`  out  1  sticky pass
- `io_failure`  out  1  sticky fail
- `exit_code`  out  32  decoded exit code, valid when `io_failure`

## Operation
- States: RUN, PASS, FAIL. Reset → RUN.
- Reset: `io_success`=0, `io_failure`=0, `exit_code`=0, FIFO empty, `cmd_valid`=0, watchdog count=0, `wr_ready`=0 while `reset` is high.
- `wr_ready`: in RUN it equals `!fifo_full`, independent of address. In PASS/FAIL it is 1, and writes are accepted and discarded.
- A write is a tohost hit when it is accepted, `wr_addr == TOHOST_ADDR`, and all `wr_strb` bits are 1. Partial-strobe tohost writes and non-tohost writes are accepted and ignored.
- Hit decode in RUN:
  - `wr_data == 0`: ignored.
  - `wr_data[0] == 1` (exit): code = `wr_data[32:1]`. If code == 0, go to PASS. Otherwise go to FAIL and latch `exit_code` = code.
  - `wr_data[0] == 0`, nonzero: push `wr_data` into the FIFO.
- FIFO:
  - Standard valid/ready with FIFO_DEPTH entries.
  - A pop occurs on `cmd_valid && cmd_ready`.
  - Pop is permitted in all states. No push occurs in PASS/FAIL.
  - Push and pop in the same cycle when not full: occupancy unchanged.
  - No write-to-read bypass.
- Watchdog (only when TIMEOUT_CYCLES > 0, only in RUN):
  - Counter clears on `retire` or any accepted write; otherwise it increments.
  - When the counter reaches TIMEOUT_CYCLES, go to FAIL with `exit_code` = 32'hFFFF_FFFF.
  - The counter saturates and never wraps.
- Sticky: PASS and FAIL are exited only by `reset`. `io_success` = (state==PASS) and `io_failure` = (state==FAIL), both mutually exclusive.

## Timing
- Exit hit accepted in cycle N → `io_success`/`io_failure` and `exit_code` high/valid from cycle N+1 (registered, no combinational path from `wr_*`).
- Push accepted in cycle N → `cmd_valid` high at N+1 if the FIFO was empty.
- `wr_ready` is combinational from FIFO full and state only, never from `wr_valid`.
- Simultaneous exit hit and watchdog expiry in the same cycle: the exit hit wins, and code comes from the data.
- Exit hit while the FIFO is full: not accepted, because `wr_ready`=0. The target must retry, and the exit is deferred until a pop frees an entry.
- `reset` asserted mid-operation: all state returns to reset values on the next edge. Queued FIFO contents are discarded.

## Test plan
- Reset, then accepted write addr 0x8000_1000, data 0x1, strb 0xFF → `io_success`=1 at next cycle; `io_failure`=0; stays 1 for 100 cycles.
- Write data 0x7 (code 3) to tohost → `io_failure`=1, `exit_code`=3 one cycle later. A later write of 0x1 does not change outputs.
- Push 4 commands (0x10, 0x20, 0x30, 0x40) with `cmd_ready`=0 → `wr_ready`=0. Then pop one → `wr_ready`=1. Drain order is 0x10, 0x20, 0x30, 0x40.
- Write 0x1 to tohost with strb 0x0F, then to 0x8000_1008 with strb 0xFF → no state change; `wr_ready` stays 1.
- TIMEOUT_CYCLES=50, no `retire`/writes → `io_failure`=1, `exit_code`=0xFFFF_FFFF at cycle 51 after reset release. With `retire` every 40 cycles, it never fails.
- Enter FAIL, assert `reset` 1 cycle → all outputs 0, FIFO empty. A subsequent exit 0x1 → PASS.

Source files
------------

// File: rtl/tohost_monitor.sv
// ---------------------------------------------------------------------------
// tohost_monitor
//
// Pass/fail detector for the test harness. Snoops the target's memory write
// channel for full-width stores to the `tohost` address and decodes them:
//   - data == 0            : ignored
//   - data[0] == 1 (exit)  : code = data[32:1]; 0 -> PASS, else FAIL(code)
//   - data[0] == 0, != 0   : host command, queued for the host-side proxy
// A no-progress watchdog (optional, TIMEOUT_CYCLES > 0) forces FAIL with
// exit code 0xFFFF_FFFF when neither a retire nor an accepted write has been
// seen for TIMEOUT_CYCLES cycles.
//
// Ports:
//   clock, reset          sole clock; synchronous active-high reset
//   wr_valid/wr_ready     write request handshake
//   wr_addr/wr_data/strb  write request payload
//   retire                instruction-retired pulse (progress)
//   cmd_valid/cmd_ready   command FIFO head handshake
//   cmd_data              command FIFO head data
//   io_success            sticky pass (registered)
//   io_failure            sticky fail (registered)
//   exit_code             decoded exit code, valid when io_failure
// ---------------------------------------------------------------------------
module tohost_monitor #(
    parameter int unsigned       ADDR_W         = 32,
    parameter int unsigned       DATA_W         = 64,
    parameter logic [ADDR_W-1:0] TOHOST_ADDR    = 32'h8000_1000,
    parameter int unsigned       FIFO_DEPTH     = 4,
    parameter int unsigned       TIMEOUT_CYCLES = 0
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                wr_valid,
    output logic                wr_ready,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic [DATA_W/8-1:0] wr_strb,
    input  logic                retire,
    output logic                cmd_valid,
    input  logic                cmd_ready,
    output logic [DATA_W-1:0]   cmd_data,
    output logic                io_success,
    output logic                io_failure,
    output logic [31:0]         exit_code
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_PASS,
        ST_FAIL
    } state_t;

    state_t state;

    // -----------------------------------------------------------------------
    // Command FIFO storage and bookkeeping
    // -----------------------------------------------------------------------
    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  count;
    logic              fifo_full;

    // Watchdog no-progress counter
    logic [31:0] wd_cnt;
    logic        wd_expired;

    // Handshake / decode
    logic        accept;
    logic        hit;
    logic        exit_hit;
    logic [31:0] exit_val;
    logic        push;
    logic        pop;

    assign fifo_full = (count == CNT_W'(FIFO_DEPTH));
    assign cmd_valid = (count != '0);
    assign cmd_data  = mem[rd_ptr];

    // Ready depends only on state and occupancy so the target never sees a
    // combinational loop through wr_valid. Once the verdict is sticky all
    // writes are swallowed so the target cannot stall on a full FIFO.
    always_comb begin
        wr_ready = 1'b0;
        if (!reset) begin
            if (state == ST_RUN) wr_ready = !fifo_full;
            else                 wr_ready = 1'b1;
        end
    end

    assign accept   = wr_valid && wr_ready;
    assign hit      = accept && (state == ST_RUN) &&
                      (wr_addr == TOHOST_ADDR) && (&wr_strb);
    assign exit_val = wr_data[32:1];
    assign exit_hit = hit && wr_data[0];
    // In RUN an accepted write implies the FIFO had room, so no full check.
    assign push     = hit && !wr_data[0] && (wr_data != '0);
    assign pop      = cmd_valid && cmd_ready;

    // Expiry looks at the registered count: the count reaching the limit
    // trips FAIL on the following edge.
    assign wd_expired = (TIMEOUT_CYCLES != 0) && (wd_cnt >= TIMEOUT_CYCLES);

    // FIFO data array; no reset needed, validity is tracked by count.
    always_ff @(posedge clock) begin
        if (!reset && push) mem[wr_ptr] <= wr_data;
    end

    // -----------------------------------------------------------------------
    // Verdict FSM, FIFO pointers and watchdog
    // -----------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= ST_RUN;
            io_success <= 1'b0;
            io_failure <= 1'b0;
            exit_code  <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            wd_cnt     <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase

            if (state == ST_RUN) begin
                // An exit hit takes priority over a simultaneous expiry.
                if (exit_hit) begin
                    if (exit_val == '0) begin
                        state      <= ST_PASS;
                        io_success <= 1'b1;
                    end else begin
                        state      <= ST_FAIL;
                        io_failure <= 1'b1;
                        exit_code  <= exit_val;
                    end
                end else if (wd_expired) begin
                    state      <= ST_FAIL;
                    io_failure <= 1'b1;
                    exit_code  <= 32'hFFFF_FFFF;
                end

                // Saturates at the limit; stays 0 when the watchdog is off.
                if (retire || accept)
                    wd_cnt <= '0;
                else if (wd_cnt < TIMEOUT_CYCLES)
                    wd_cnt <= wd_cnt + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_tohost_monitor.sv
module tb_tohost_monitor;

    localparam logic [31:0] TH = 32'h8000_1000;
    localparam int DEPTH = 4;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset;
    logic        wr_valid;
    logic [31:0] wr_addr;
    logic [63:0] wr_data;
    logic [7:0]  wr_strb;
    logic        retire;
    logic        cmd_ready;

    logic        wr_ready, cmd_valid, io_success, io_failure;
    logic [63:0] cmd_data;
    logic [31:0] exit_code;

    logic        w_wr_ready, w_cmd_valid, w_io_success, w_io_failure;
    logic [63:0] w_cmd_data;
    logic [31:0] w_exit_code;

    int checks = 0;
    int errors = 0;

    // reference model state: 0 run, 1 pass, 2 fail
    int          m_state;
    logic [31:0] m_code;
    logic [63:0] m_q[$];

    tohost_monitor dut (
        .clock(clock), .reset(reset),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_strb(wr_strb), .retire(retire),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data),
        .io_success(io_success), .io_failure(io_failure), .exit_code(exit_code)
    );

    tohost_monitor #(.TIMEOUT_CYCLES(50)) dut_wd (
        .clock(clock), .reset(reset),
        .wr_valid(wr_valid), .wr_ready(w_wr_ready), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_strb(wr_strb), .retire(retire),
        .cmd_valid(w_cmd_valid), .cmd_ready(cmd_ready), .cmd_data(w_cmd_data),
        .io_success(w_io_success), .io_failure(w_io_failure), .exit_code(w_exit_code)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive_idle();
        wr_valid  = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;
        wr_strb   = '0;
        retire    = 1'b0;
        cmd_ready = 1'b0;
    endtask

    task automatic do_reset();
        drive_idle();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [63:0] d, input logic [7:0] s);
        wr_valid = 1'b1;
        wr_addr  = a;
        wr_data  = d;
        wr_strb  = s;
        tick();
        wr_valid = 1'b0;
    endtask

    task automatic model_edge();
        bit rdy, acc, pop, hit;
        logic [31:0] code;
        if (reset) begin
            m_state = 0;
            m_code  = '0;
            m_q.delete();
            return;
        end
        rdy = (m_state != 0) || (m_q.size() < DEPTH);
        acc = wr_valid && rdy;
        pop = (m_q.size() > 0) && cmd_ready;
        hit = acc && (m_state == 0) && (wr_addr == TH) && (wr_strb == 8'hFF);
        if (pop) void'(m_q.pop_front());
        if (hit && wr_data != 64'd0) begin
            if (wr_data % 2 == 1) begin
                code = 32'((wr_data >> 1) & 64'hFFFF_FFFF);
                if (code == 0) m_state = 1;
                else begin
                    m_state = 2;
                    m_code  = code;
                end
            end else begin
                m_q.push_back(wr_data);
            end
        end
    endtask

    task automatic test_reset();
        drive_idle();
        reset = 1'b1;
        tick();
        tick();
        checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL reset_wr_ready got=%0b exp=0", wr_ready); end
        checks++; if (io_success !== 1'b0) begin errors++; $display("FAIL reset_success got=%0b exp=0", io_success); end
        checks++; if (io_failure !== 1'b0) begin errors++; $display("FAIL reset_failure got=%0b exp=0", io_failure); end
        checks++; if (exit_code !== 32'd0) begin errors++; $display("FAIL reset_exit_code got=%h exp=0", exit_code); end
        checks++; if (cmd_valid !== 1'b0) begin errors++; $display("FAIL reset_cmd_valid got=%0b exp=0", cmd_valid); end
        reset = 1'b0;
        #1;
        checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready got=%0b exp=1", wr_ready); end
    endtask

    task automatic test_pass();
        int bad;
        do_reset();
        do_write(TH, 64'h1, 8'hFF);
        checks++; if (io_success !== 1'b1) begin errors++; $display("FAIL pass_success got=%0b exp=1", io_success); end
        checks++; if (io_failure !== 1'b0) begin errors++; $display("FAIL pass_failure got=%0b exp=0", io_failure); end
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (io_success !== 1'b1 || io_failure !== 1'b0) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL pass_sticky got=%0d_bad_cycles exp=0", bad); end
        checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL pass_wr_ready got=%0b exp=1", wr_ready); end
    endtask

    task automatic test_fail();
        do_reset();
        do_write(TH, 64'h7, 8'hFF);
        checks++; if (io_failure !== 1'b1) begin errors++; $display("FAIL fail_flag got=%0b exp=1", io_failure); end
        checks++; if (exit_code !== 32'd3) begin errors++; $display("FAIL fail_code got=%h exp=3", exit_code); end
        checks++; if (io_success !== 1'b0) begin errors++; $display("FAIL fail_success got=%0b exp=0", io_success); end
        do_write(TH, 64'h1, 8'hFF);
        tick();
        checks++; if (io_success !== 1'b0 || io_failure !== 1'b1 || exit_code !== 32'd3) begin
            errors++; $display("FAIL fail_sticky got=s%0b_f%0b_c%h exp=s0_f1_c3", io_success, io_failure, exit_code); end
        // widest code; bits above 32 must not leak in
        do_reset();
        do_write(TH, 64'hF000_0001_FFFF_FFFF, 8'hFF);
        checks++; if (exit_code !== 32'hFFFF_FFFF) begin errors++; $display("FAIL fail_wide_code got=%h exp=ffffffff", exit_code); end
        do_reset();
        do_write(TH, 64'hF000_0000_0000_0005, 8'hFF);
        checks++; if (exit_code !== 32'd2) begin errors++; $display("FAIL fail_high_bits got=%h exp=2", exit_code); end
    endtask

    task automatic test_fifo();
        logic [63:0] exp_d[5];
        exp_d = '{64'h10, 64'h20, 64'h30, 64'h40, 64'h50};
        do_reset();
        do_write(TH, 64'h10, 8'hFF);
        checks++; if (cmd_valid !== 1'b1 || cmd_data !== 64'h10) begin
            errors++; $display("FAIL fifo_first got=v%0b_%h exp=v1_10", cmd_valid, cmd_data); end
        do_write(TH, 64'h20, 8'hFF);
        do_write(TH, 64'h30, 8'hFF);
        do_write(TH, 64'h40, 8'hFF);
        checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL fifo_full_ready got=%0b exp=0", wr_ready); end
        cmd_ready = 1'b1;
        #1;
        checks++; if (cmd_data !== exp_d[0]) begin errors++; $display("FAIL fifo_order0 got=%h exp=%h", cmd_data, exp_d[0]); end
        tick();
        cmd_ready = 1'b0;
        checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL fifo_pop_ready got=%0b exp=1", wr_ready); end
        do_write(TH, 64'h50, 8'hFF);
        // exit held while full: deferred until an entry frees up
        wr_valid = 1'b1; wr_addr = TH; wr_data = 64'h1; wr_strb = 8'hFF;
        tick();
        checks++; if (io_success !== 1'b0) begin errors++; $display("FAIL fifo_exit_blocked got=%0b exp=0", io_success); end
        cmd_ready = 1'b1;
        #1;
        checks++; if (cmd_data !== exp_d[1]) begin errors++; $display("FAIL fifo_order1 got=%h exp=%h", cmd_data, exp_d[1]); end
        tick();
        cmd_ready = 1'b0;
        checks++; if (io_success !== 1'b0) begin errors++; $display("FAIL fifo_exit_same_pop got=%0b exp=0", io_success); end
        tick();
        wr_valid = 1'b0;
        checks++; if (io_success !== 1'b1) begin errors++; $display("FAIL fifo_exit_retry got=%0b exp=1", io_success); end
        cmd_ready = 1'b1;
        for (int i = 2; i < 5; i++) begin
            #1;
            checks++; if (cmd_valid !== 1'b1 || cmd_data !== exp_d[i]) begin
                errors++; $display("FAIL fifo_order%0d got=v%0b_%h exp=v1_%h", i, cmd_valid, cmd_data, exp_d[i]); end
            tick();
        end
        cmd_ready = 1'b0;
        checks++; if (cmd_valid !== 1'b0) begin errors++; $display("FAIL fifo_drained got=%0b exp=0", cmd_valid); end
    endtask

    task automatic test_ignored();
        do_reset();
        do_write(TH, 64'h1, 8'h0F);
        checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL ign_ready got=%0b exp=1", wr_ready); end
        do_write(TH + 32'd8, 64'h1, 8'hFF);
        do_write(TH, 64'h0, 8'hFF);
        do_write(TH, 64'h20, 8'hF0);
        checks++; if (io_success !== 1'b0 || io_failure !== 1'b0 || cmd_valid !== 1'b0 || wr_ready !== 1'b1) begin
            errors++; $display("FAIL ign_state got=s%0b_f%0b_v%0b_r%0b exp=s0_f0_v0_r1", io_success, io_failure, cmd_valid, wr_ready); end
    endtask

    task automatic test_watchdog();
        int bad;
        do_reset();
        bad = 0;
        for (int k = 1; k <= 50; k++) begin
            tick();
            if (w_io_failure !== 1'b0) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL wd_early got=%0d_bad_cycles exp=0", bad); end
        tick();
        checks++; if (w_io_failure !== 1'b1 || w_exit_code !== 32'hFFFF_FFFF || w_io_success !== 1'b0) begin
            errors++; $display("FAIL wd_expire got=f%0b_c%h exp=f1_ffffffff", w_io_failure, w_exit_code); end
        checks++; if (io_failure !== 1'b0) begin errors++; $display("FAIL wd_disabled got=%0b exp=0", io_failure); end

        // progress every 40 cycles keeps it alive; a command push also counts
        do_reset();
        do_write(TH, 64'h88, 8'hFF);
        checks++; if (w_cmd_valid !== 1'b1 || w_cmd_data !== 64'h88) begin
            errors++; $display("FAIL wd_cmd got=v%0b_%h exp=v1_88", w_cmd_valid, w_cmd_data); end
        cmd_ready = 1'b1;
        tick();
        cmd_ready = 1'b0;
        bad = 0;
        for (int i = 0; i < 300; i++) begin
            retire = (i % 40 == 39);
            tick();
            if (w_io_failure !== 1'b0) bad++;
        end
        retire = 1'b0;
        checks++; if (bad != 0) begin errors++; $display("FAIL wd_retire got=%0d_bad_cycles exp=0", bad); end
        checks++; if (w_wr_ready !== 1'b1) begin errors++; $display("FAIL wd_ready got=%0b exp=1", w_wr_ready); end

        // exit hit in the expiry cycle wins
        do_reset();
        for (int k = 1; k <= 50; k++) tick();
        do_write(TH, 64'h7, 8'hFF);
        checks++; if (w_io_failure !== 1'b1 || w_exit_code !== 32'd3) begin
            errors++; $display("FAIL wd_exit_priority got=f%0b_c%h exp=f1_3", w_io_failure, w_exit_code); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        do_write(TH, 64'h11 << 1, 8'hFF);
        do_write(TH, 64'h44, 8'hFF);
        do_write(TH, 64'h5, 8'hFF);
        checks++; if (io_failure !== 1'b1 || exit_code !== 32'd2 || cmd_valid !== 1'b1) begin
            errors++; $display("FAIL mid_setup got=f%0b_c%h_v%0b exp=f1_2_v1", io_failure, exit_code, cmd_valid); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        checks++; if (io_failure !== 1'b0 || io_success !== 1'b0 || exit_code !== 32'd0 || cmd_valid !== 1'b0 || wr_ready !== 1'b1) begin
            errors++; $display("FAIL mid_reset got=s%0b_f%0b_c%h_v%0b_r%0b exp=all0_r1", io_success, io_failure, exit_code, cmd_valid, wr_ready); end
        do_write(TH, 64'h1, 8'hFF);
        checks++; if (io_success !== 1'b1 || io_failure !== 1'b0) begin
            errors++; $display("FAIL mid_pass got=s%0b_f%0b exp=s1_f0", io_success, io_failure); end
    endtask

    task automatic test_random();
        int r;
        logic [63:0] d;
        bit exp_rdy;
        do_reset();
        m_state = 0;
        m_code  = '0;
        m_q.delete();
        for (int i = 0; i < 800; i++) begin
            reset    = ($urandom_range(0, 99) < 2);
            wr_valid = ($urandom_range(0, 99) < 70);
            r = $urandom_range(0, 99);
            wr_addr = (r < 65) ? TH : ((r < 80) ? TH + 32'd8 : $urandom());
            wr_strb = ($urandom_range(0, 99) < 85) ? 8'hFF : 8'($urandom());
            r = $urandom_range(0, 99);
            if (r < 3)       d = 64'h1;
            else if (r < 6)  d = {$urandom(), $urandom()} | 64'h1;
            else if (r < 12) d = 64'h0;
            else             d = {$urandom(), $urandom()} & ~64'h1;
            wr_data   = d;
            cmd_ready = ($urandom_range(0, 99) < 40);
            retire    = 1'($urandom_range(0, 1));
            #1;
            exp_rdy = !reset && ((m_state != 0) || (m_q.size() < DEPTH));
            checks++; if (wr_ready !== exp_rdy) begin errors++; $display("FAIL rnd_ready cyc=%0d got=%0b exp=%0b", i, wr_ready, exp_rdy); end
            checks++; if (cmd_valid !== (m_q.size() > 0)) begin errors++; $display("FAIL rnd_cmd_valid cyc=%0d got=%0b exp=%0b", i, cmd_valid, m_q.size() > 0); end
            if (m_q.size() > 0) begin
                checks++; if (cmd_data !== m_q[0]) begin errors++; $display("FAIL rnd_cmd_data cyc=%0d got=%h exp=%h", i, cmd_data, m_q[0]); end
            end
            checks++; if (io_success !== (m_state == 1)) begin errors++; $display("FAIL rnd_success cyc=%0d got=%0b exp=%0b", i, io_success, m_state == 1); end
            checks++; if (io_failure !== (m_state == 2)) begin errors++; $display("FAIL rnd_failure cyc=%0d got=%0b exp=%0b", i, io_failure, m_state == 2); end
            checks++; if (exit_code !== m_code) begin errors++; $display("FAIL rnd_exit_code cyc=%0d got=%h exp=%h", i, exit_code, m_code); end
            model_edge();
            tick();
        end
        reset = 1'b0;
        drive_idle();
    endtask

    initial begin
        reset = 1'b1;
        drive_idle();
        test_reset();
        test_pass();
        test_fail();
        test_fifo();
        test_ignored();
        test_watchdog();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
